// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } lcd_state_e;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_RDST  = 2'b01;
  localparam logic [1:0] OP_RDDAT = 2'b10;
  localparam logic [1:0] OP_PWR   = 2'b11;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_HOME2 = 8'h03;

  localparam int unsigned T_SETUP_DEF     = 32'd8;
  localparam int unsigned T_PULSE_DEF     = 32'd25;
  localparam int unsigned T_HOLD_DEF      = 32'd4;
  localparam int unsigned T_EXEC_DEF      = 32'd2000;
  localparam int unsigned T_EXEC_LONG_DEF = 32'd82000;
  localparam int unsigned CNT_W_DEF       = 32'd17;

  // Clear and return-home need the long execution wait.
  function automatic logic is_long_cmd(input logic [7:0] b);
    return (b == CMD_CLEAR) || (b == CMD_HOME) || (b == CMD_HOME2);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Down-counter timing one bus phase; done marks the last cycle of the loaded interval.
module lcd_timer #(
  parameter int unsigned CNT_W = 32'd17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q holds the cycles remaining including the current one; a zero load still lasts one cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 bus sequencer: turns one posted byte operation into a fully timed en/rw/rs cycle.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP     = T_SETUP_DEF,
  parameter int unsigned T_PULSE     = T_PULSE_DEF,
  parameter int unsigned T_HOLD      = T_HOLD_DEF,
  parameter int unsigned T_EXEC      = T_EXEC_DEF,
  parameter int unsigned T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rw,
  output logic        lcd_rs,
  inout  wire  [7:0]  lcd_data
);

  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d, rw_q, rw_d;
  logic [7:0]       byte_q, byte_d, rd_byte_q, rd_byte_d;
  logic             rd_valid_q, rd_valid_d, lcd_on_q, lcd_on_d;
  logic             lcd_en_q, lcd_en_d, lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d;
  logic             tmr_load, tmr_done, busy, bus_wr, pwr_wr, bus_phase;
  logic [CNT_W-1:0] tmr_val;
  logic [1:0]       op;
  logic             unused_data;

  assign op          = data_in[9:8];
  assign unused_data = ^data_in[31:10];
  assign busy        = (state_q != IDLE);
  assign bus_wr      = stb & we & (~addr | (op != OP_PWR));
  assign pwr_wr      = stb & we & addr & (op == OP_PWR);
  assign ack         = stb & ~(bus_wr & busy);

  lcd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state, latched operation fields and registered pin values.
  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    byte_d     = byte_q;
    rd_byte_d  = rd_byte_q;
    rd_valid_d = rd_valid_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    lcd_on_d   = pwr_wr ? data_in[0] : lcd_on_q;
    case (state_q)
      IDLE: begin
        if (bus_wr) begin
          rs_d       = ~addr | (op == OP_RDDAT);
          rw_d       = addr & ((op == OP_RDST) | (op == OP_RDDAT));
          byte_d     = data_in[7:0];
          rd_valid_d = rd_valid_q & ~rw_d;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(T_SETUP);
          state_d    = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_PULSE);
          state_d  = PULSE;
        end else begin
          state_d = SETUP;
        end
      end
      PULSE: begin
        if (tmr_done) begin
          if (rw_q) begin
            rd_byte_d  = lcd_data;
            rd_valid_d = 1'b1;
          end else begin
            rd_byte_d = rd_byte_q;
          end
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_HOLD);
          state_d  = HOLD;
        end else begin
          state_d = PULSE;
        end
      end
      HOLD: begin
        // A status read has no execution time on the panel side.
        if (tmr_done && !rs_q && rw_q) begin
          state_d = IDLE;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = (!rs_q && !rw_q && is_long_cmd(byte_q)) ? CNT_W'(T_EXEC_LONG)
                                                               : CNT_W'(T_EXEC);
          state_d  = EXEC;
        end else begin
          state_d = HOLD;
        end
      end
      EXEC: begin
        if (tmr_done) state_d = IDLE;
        else          state_d = EXEC;
      end
      default: state_d = IDLE;
    endcase
    bus_phase = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
    lcd_en_d  = (state_d == PULSE);
    lcd_rs_d  = bus_phase & rs_d;
    lcd_rw_d  = bus_phase & rw_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      byte_q     <= 8'h00;
      rd_byte_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      lcd_on_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      byte_q     <= byte_d;
      rd_byte_q  <= rd_byte_d;
      rd_valid_q <= rd_valid_d;
      lcd_on_q   <= lcd_on_d;
      lcd_en_q   <= lcd_en_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
    end
  end

  assign lcd_on   = lcd_on_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = lcd_rw_q;
  assign lcd_data = lcd_rw_q ? 8'hzz : byte_q;
  assign data_out = (stb && !we) ? (addr ? {29'b0, lcd_on_q, rd_valid_q, busy}
                                         : {24'b0, rd_byte_q})
                                 : 32'h0;

endmodule
